// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - rectangle-fill / vsync-aligned swap command producer for the frame buffer write port
// Optional clipping at command accept when FB_RECT_WRITER_CLIP_EN is defined.
module fb_rect_writer #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  localparam int FB_SIZE  = $clog2(FB_WIDTH * FB_HEIGHT),
  localparam int XW       = $clog2(FB_WIDTH),
  localparam int YW       = $clog2(FB_HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [XW-1:0]      cmd_x,
  input  logic [YW-1:0]      cmd_y,
  input  logic [XW-1:0]      cmd_w,
  input  logic [YW-1:0]      cmd_h,
  input  logic [15:0]        cmd_color,
  input  logic               vsync_in,
  output logic [15:0]        write_data,
  output logic [FB_SIZE-1:0] write_addr,
  output logic               write_enable,
  output logic               swap_buffer,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, FILL, SWAP_WAIT, SWAP_DONE} state_t;

  state_t             state;
  logic               vsync_prev;
  logic [XW-1:0]      col;
  logic [XW-1:0]      w_last;
  logic [YW-1:0]      row;
  logic [YW-1:0]      h_last;
  logic [FB_SIZE-1:0] row_base;
  logic [XW-1:0]      eff_w;
  logic [YW-1:0]      eff_h;
  logic [FB_SIZE-1:0] start_addr;

  always_comb begin
    eff_w = '0;
    eff_h = '0;
`ifdef FB_RECT_WRITER_CLIP_EN
    if (cmd_x < XW'(FB_WIDTH) && cmd_y < YW'(FB_HEIGHT)) begin
      eff_w = (cmd_w > XW'(FB_WIDTH) - cmd_x) ? XW'(FB_WIDTH) - cmd_x : cmd_w;
      eff_h = (cmd_h > YW'(FB_HEIGHT) - cmd_y) ? YW'(FB_HEIGHT) - cmd_y : cmd_h;
    end
`else
    eff_w = cmd_w;
    eff_h = cmd_h;
`endif
  end

  // The only multiply sits at accept; the per-row step inside the fill is an add.
  assign start_addr = FB_SIZE'(cmd_x) + FB_SIZE'(cmd_y) * FB_SIZE'(FB_WIDTH);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      write_enable <= 1'b0;
      swap_buffer  <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      vsync_prev   <= 1'b0;
      col          <= '0;
      row          <= '0;
      w_last       <= '0;
      h_last       <= '0;
      row_base     <= '0;
    end else begin
      vsync_prev <= vsync_in;
      case (state)
        IDLE: begin
          write_enable <= 1'b0;
          swap_buffer  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            if (cmd_op) begin
              state     <= SWAP_WAIT;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
            end else if (eff_w != '0 && eff_h != '0) begin
              state        <= FILL;
              cmd_ready    <= 1'b0;
              busy         <= 1'b1;
              write_enable <= 1'b1;
              write_addr   <= start_addr;
              row_base     <= start_addr;
              write_data   <= cmd_color;
              col          <= '0;
              row          <= '0;
              w_last       <= eff_w - 1'b1;
              h_last       <= eff_h - 1'b1;
            end
          end
        end
        FILL: begin
          if (col == w_last) begin
            if (row == h_last) begin
              write_enable <= 1'b0;
              state        <= IDLE;
              cmd_ready    <= 1'b1;
              busy         <= 1'b0;
            end else begin
              col        <= '0;
              row        <= row + 1'b1;
              row_base   <= row_base + FB_SIZE'(FB_WIDTH);
              write_addr <= row_base + FB_SIZE'(FB_WIDTH);
            end
          end else begin
            col        <= col + 1'b1;
            write_addr <= write_addr + 1'b1;
          end
        end
        SWAP_WAIT: begin
          // vsync_prev was loaded in the accept cycle, so an edge landing there is ignored.
          if (vsync_in && !vsync_prev) begin
            swap_buffer <= 1'b1;
            state       <= SWAP_DONE;
          end
        end
        SWAP_DONE: begin
          swap_buffer <= 1'b0;
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          busy        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - scoreboard bench for fb_rect_writer
// Expected writes/swaps are queued by the stimulus and popped by a negedge monitor.
module tb_fb_rect_writer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [15:0] cmd_color;
  logic        vsync_in;
  logic [15:0] write_data;
  logic [15:0] write_addr;
  logic        write_enable;
  logic        swap_buffer;
  logic        busy;

  fb_rect_writer dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .vsync_in     (vsync_in),
    .write_data   (write_data),
    .write_addr   (write_addr),
    .write_enable (write_enable),
    .swap_buffer  (swap_buffer),
    .busy         (busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit is_swap;
    int addr;
    int data;
    int cyc;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_n;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    ev_t e;
    if (write_enable && swap_buffer) chk("we_swap_overlap", 1, 0);
    if (write_enable || swap_buffer) begin
      if (expq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("event_kind", int'(swap_buffer), int'(e.is_swap));
        chk("event_cycle", cyc, e.cyc);
        if (!e.is_swap) begin
          chk("write_addr", int'(write_addr), e.addr);
          chk("write_data", int'(write_data), e.data);
        end
      end
    end
  end

  function automatic void eff_dims(input int x, input int y, input int w, input int h,
                                   output int we, output int he);
`ifdef FB_RECT_WRITER_CLIP_EN
    if (x >= 320 || y >= 180) begin
      we = 0;
      he = 0;
    end else begin
      we = (w < 320 - x) ? w : 320 - x;
      he = (h < 180 - y) ? h : 180 - y;
    end
`else
    we = w;
    he = h;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with cmd_valid still high.
  task automatic issue(input bit op, input int x, input int y, input int w, input int h,
                       input int color, input int limit);
    int we, he, k;
    ev_t e;
    cmd_op    = op;
    cmd_x     = 9'(x);
    cmd_y     = 8'(y);
    cmd_w     = 9'(w);
    cmd_h     = 8'(h);
    cmd_color = 16'(color);
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk_in);
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    last_n = cyc;
    if (!op) begin
      eff_dims(x, y, w, h, we, he);
      k = 0;
      for (int r = 0; r < he; r++) begin
        for (int c = 0; c < we; c++) begin
          if (k < limit) begin
            e.is_swap = 1'b0;
            e.addr    = ((x + c) + 320 * (y + r)) % 65536;
            e.data    = color;
            e.cyc     = last_n + 1 + k;
            expq.push_back(e);
          end
          k++;
        end
      end
    end
    @(negedge clk_in);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_in);
  endtask

  task automatic vsync_rise(input bit expect_swap);
    ev_t e;
    vsync_in = 1'b1;
    if (expect_swap) begin
      e.is_swap = 1'b1;
      e.addr    = 0;
      e.data    = 0;
      e.cyc     = cyc + 1;
      expq.push_back(e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m;
    rst_n_in  = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
    vsync_in  = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_swap", swap_buffer, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);

    // Basic 3x2 fill; last write N+6, ready at N+7.
    issue(0, 2, 1, 3, 2, 'hF800, 1000);
    cmd_valid = 1'b0;
    n0 = last_n;
    wait_cyc(n0 + 6);
    chk("fill_ready_low_last", cmd_ready, 0);
    wait_cyc(n0 + 7);
    chk("fill_ready_high", cmd_ready, 1);

    // Zero-size fills.
    issue(0, 5, 5, 0, 5, 'h1234, 1000);
    cmd_valid = 1'b0;
    chk("w0_ready", cmd_ready, 1);
    chk("w0_busy", busy, 0);
    issue(0, 5, 5, 3, 0, 'h1234, 1000);
    cmd_valid = 1'b0;
    chk("h0_ready", cmd_ready, 1);
    chk("h0_busy", busy, 0);
    repeat (3) @(negedge clk_in);

    // Swap with vsync low at accept, rising 10 cycles later.
    issue(1, 0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    chk("swap_busy", busy, 1);
    repeat (9) @(negedge clk_in);
    m = cyc;
    vsync_rise(1'b1);
    @(negedge clk_in);
    chk("swap_ready_m1", cmd_ready, 0);
    @(negedge clk_in);
    chk("swap_ready_m2", cmd_ready, 1);
    chk("swap_cycle_track", cyc, m + 2);
    vsync_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Edge whose high sample is the accept cycle must be ignored.
    vsync_in = 1'b1;
    issue(1, 0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk_in);
    chk("swap_hold_accept_edge", cmd_ready, 0);
    vsync_in = 1'b0;
    repeat (3) @(negedge clk_in);
    vsync_rise(1'b1);
    repeat (3) @(negedge clk_in);
    vsync_in = 1'b0;
    @(negedge clk_in);

    // vsync already high well before accept.
    vsync_in = 1'b1;
    repeat (3) @(negedge clk_in);
    issue(1, 0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("swap_hold_high", busy, 1);
    vsync_in = 1'b0;
    repeat (2) @(negedge clk_in);
    vsync_rise(1'b1);
    repeat (3) @(negedge clk_in);
    vsync_in = 1'b0;

    // Edge-of-frame and wrap cases (clipped or raw depending on the macro).
    issue(0, 318, 179, 5, 4, 'h07E0, 1000);
    cmd_valid = 1'b0;
    repeat (25) @(negedge clk_in);
    issue(0, 320, 10, 4, 2, 'h001F, 1000);
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk_in);
    issue(0, 300, 255, 2, 1, 'hABCD, 1000);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk_in);

    // Reset mid-way through a full-frame fill.
    issue(0, 0, 0, 320, 180, 'hFFFF, 50);
    cmd_valid = 1'b0;
    n0 = last_n;
    wait_cyc(n0 + 50);
    #2 rst_n_in = 1'b0;
    #1;
    chk("async_rst_we", write_enable, 0);
    chk("async_rst_ready", cmd_ready, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_addr", write_addr, 0);
    chk("async_rst_data", write_data, 0);
    chk("async_rst_swap", swap_buffer, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);
    issue(0, 10, 20, 2, 2, 'h5555, 1000);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk_in);

    // Back-to-back FILL 1x1 then SWAP with cmd_valid held.
    issue(0, 7, 7, 1, 1, 'hAAAA, 1000);
    n0 = last_n;
    issue(1, 0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b0;
    chk("b2b_swap_accept_cycle", last_n, n0 + 2);
    repeat (4) @(negedge clk_in);
    vsync_rise(1'b1);
    repeat (3) @(negedge clk_in);
    vsync_in = 1'b0;
    repeat (3) @(negedge clk_in);

    chk("queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
